// File: rtl/cic_interp.sv
// cic_interp: N-stage CIC interpolator (M=1), one input sample per 2**RATE_LOG2 clocks, one output per clock
// Ports: CLK clock; RST sync active-high reset; x_in/x_valid/x_ready input sample handshake (accept only at phase 0);
//        gain output left-shift 0..7 (latched at phase 0); y_out/y_valid registered saturated output;
//        underrun sticky flag for a phase-0 slot with no valid input.
module cic_interp #(
  parameter int IN_W      = 16,
  parameter int OUT_W     = 16,
  parameter int N_STAGES  = 3,
  parameter int RATE_LOG2 = 6
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [IN_W-1:0]  x_in,
  input  logic             x_valid,
  output logic             x_ready,
  input  logic [2:0]       gain,
  output logic [OUT_W-1:0] y_out,
  output logic             y_valid,
  output logic             underrun
);
  localparam int W       = IN_W + N_STAGES*RATE_LOG2;
  localparam int SH_BASE = (N_STAGES-1)*RATE_LOG2 + IN_W - OUT_W;
  localparam logic [OUT_W-1:0] MAXV = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic [OUT_W-1:0] MINV = {1'b1, {(OUT_W-1){1'b0}}};
  logic [RATE_LOG2-1:0] r_phase;
  logic [IN_W-1:0]      r_last;
  logic [W-1:0]         r_d [N_STAGES];
  logic [W-1:0]         r_int [N_STAGES];
  logic [W-1:0]         r_comb;
  logic [2:0]           r_gain;
  logic [N_STAGES:0]    r_vp;
  logic [IN_W-1:0]      w_s;
  logic [W-1:0]         w_c [N_STAGES+1];
  logic [W-1:0]         w_z;
  logic [W-1:0]         w_v;
  logic [OUT_W-1:0]     w_y;
  logic                 w_p0;
  logic                 w_fit;
  assign w_p0    = r_phase == '0;
  assign x_ready = w_p0 & ~RST;
  // a missing sample repeats the previous one so the output holds its level
  assign w_s     = x_valid ? x_in : r_last;
  always_comb begin
    w_c[0] = {{(W-IN_W){w_s[IN_W-1]}}, w_s};
    for (int k = 0; k < N_STAGES; k++) w_c[k+1] = w_c[k] - r_d[k];
  end
  // zero-stuffing: the comb result enters the integrators for one cycle only
  assign w_z   = r_phase == RATE_LOG2'(1) ? r_comb : '0;
  assign w_v   = W'($signed(r_int[N_STAGES-1]) >>> (SH_BASE - 32'(r_gain)));
  assign w_fit = (&w_v[W-1:OUT_W-1]) | ~(|w_v[W-1:OUT_W-1]);
  assign w_y   = w_fit ? w_v[OUT_W-1:0] : (w_v[W-1] ? MINV : MAXV);
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_phase  <= '0;
      r_last   <= '0;
      r_comb   <= '0;
      r_gain   <= '0;
      r_vp     <= '0;
      y_out    <= '0;
      y_valid  <= 1'b0;
      underrun <= 1'b0;
      for (int k = 0; k < N_STAGES; k++) begin
        r_d[k]   <= '0;
        r_int[k] <= '0;
      end
    end else begin
      r_phase <= r_phase + 1'b1;
      if (w_p0) begin
        r_last <= w_s;
        r_gain <= gain;
        r_comb <= w_c[N_STAGES];
        for (int k = 0; k < N_STAGES; k++) r_d[k] <= w_c[k];
        if (!x_valid) underrun <= 1'b1;
      end
      r_int[0] <= r_int[0] + w_z;
      for (int k = 1; k < N_STAGES; k++) r_int[k] <= r_int[k] + r_int[k-1];
      // accept marker travels alongside the sample through the pipeline
      r_vp    <= {r_vp[N_STAGES-1:0], w_p0 & x_valid};
      y_valid <= y_valid | r_vp[N_STAGES];
      y_out   <= w_y;
    end
  end
endmodule
